// File: rtl/rtc_bcd_core.sv
// rtl/rtc_bcd_core.sv - BCD real-time clock core with alarm, 12/24h display and second strobe
//
// Ports:
//   clk, rst_n     - system clock, synchronous active-low reset
//   work_en        - 1 = clock runs, 0 = stopped (time digits writable)
//   set_flag       - one-cycle write strobe; set_target selects time (0) or alarm (1)
//   set_pos        - digit select 0..5 = s_l,s_h,m_l,m_h,h_l,h_h (6,7 ignored)
//   set_data       - BCD value to write
//   mode_12h       - 1 = 12-hour display conversion of the hour digits
//   alarm_en       - enables alarm_hit
//   data           - registered display digits {h_h,h_l,m_h,m_l,s_h,s_l}
//   point, sign    - constant decimal-point pattern and sign for the display bus
//   pm             - registered PM indicator (12-hour mode only)
//   sec_pulse      - one-cycle strobe per second advance
//   alarm_hit      - one-cycle strobe when time advances onto the alarm time
module rtc_bcd_core #(
    parameter int         TICK_DIV    = 50_000_000,
    parameter bit         CLR_ON_STOP = 1'b0,
    parameter logic [5:0] POINT_MASK  = 6'b010100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        work_en,
    input  logic        set_flag,
    input  logic        set_target,
    input  logic [2:0]  set_pos,
    input  logic [3:0]  set_data,
    input  logic        mode_12h,
    input  logic        alarm_en,
    output logic [23:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        pm,
    output logic        sec_pulse,
    output logic        alarm_hit
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [5:0][3:0] tim, tim_n, tim_adv;
    logic [5:0][3:0] alm, alm_n;
    logic [PW-1:0]   presc;
    logic            work_d;
    logic            match_q;
    logic            tick, stop_edge, wr_block, wr_time, wr_alarm;
    logic [4:0]      h_bin, h_disp;
    logic [3:0]      hh, hl;
    logic            pm_n;

    assign point = POINT_MASK;
    assign sign  = 1'b0;

    // One-second BCD advance with the 23:59:59 -> 00:00:00 rollover.
    function automatic logic [5:0][3:0] advance(input logic [5:0][3:0] t);
        logic [5:0][3:0] n;
        n = t;
        if (t[0] != 4'd9) n[0] = t[0] + 4'd1;
        else begin
            n[0] = 4'd0;
            if (t[1] != 4'd5) n[1] = t[1] + 4'd1;
            else begin
                n[1] = 4'd0;
                if (t[2] != 4'd9) n[2] = t[2] + 4'd1;
                else begin
                    n[2] = 4'd0;
                    if (t[3] != 4'd5) n[3] = t[3] + 4'd1;
                    else begin
                        n[3] = 4'd0;
                        if (t[5] == 4'd2 && t[4] == 4'd3) begin
                            n[5] = 4'd0;
                            n[4] = 4'd0;
                        end else if (t[4] == 4'd9) begin
                            n[4] = 4'd0;
                            n[5] = t[5] + 4'd1;
                        end else begin
                            n[4] = t[4] + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    // Range check for a single-digit write; hour validity uses the other
    // hour digit as currently stored in the same register set.
    function automatic logic valid_write(input logic [5:0][3:0] cur,
                                         input logic [2:0] pos,
                                         input logic [3:0] val);
        logic ok;
        ok = (pos <= 3'd5) && (val <= 4'd9);
        case (pos)
            3'd1, 3'd3: if (val > 4'd5) ok = 1'b0;
            3'd4:       if (cur[5] == 4'd2 && val > 4'd3) ok = 1'b0;
            3'd5:       if (val > 4'd2 || (val == 4'd2 && cur[4] > 4'd3)) ok = 1'b0;
            default:    ;
        endcase
        return ok;
    endfunction

    always_comb begin
        stop_edge = work_d & ~work_en;
        tick      = work_en && (presc == PRESC_MAX);
        tim_adv   = advance(tim);
        // The clearing stop edge swallows any write issued in the same cycle.
        wr_block  = stop_edge && CLR_ON_STOP;
        wr_time   = set_flag && !set_target && !work_en && !wr_block &&
                    valid_write(tim, set_pos, set_data);
        wr_alarm  = set_flag && set_target && !wr_block &&
                    valid_write(alm, set_pos, set_data);

        tim_n = tim;
        if (wr_block) begin
            tim_n = '0;
        end else if (tick) begin
            tim_n = tim_adv;
        end else if (wr_time) begin
            for (int i = 0; i < 6; i++)
                if (set_pos == 3'(i)) tim_n[i] = set_data;
        end

        alm_n = alm;
        if (wr_alarm) begin
            for (int i = 0; i < 6; i++)
                if (set_pos == 3'(i)) alm_n[i] = set_data;
        end
    end

    // Hour display conversion: to binary, fold into 12-hour range, back to BCD.
    always_comb begin
        h_bin = (tim[5] == 4'd2) ? 5'd20 : (tim[5] == 4'd1) ? 5'd10 : 5'd0;
        h_bin = h_bin + {1'b0, tim[4]};
        h_disp = h_bin;
        pm_n   = 1'b0;
        if (mode_12h) begin
            if (h_bin == 5'd0) begin
                h_disp = 5'd12;
            end else if (h_bin > 5'd12) begin
                h_disp = h_bin - 5'd12;
                pm_n   = 1'b1;
            end else begin
                pm_n   = (h_bin == 5'd12);
            end
        end
        if (h_disp >= 5'd20) begin
            hh = 4'd2;
            hl = 4'(h_disp - 5'd20);
        end else if (h_disp >= 5'd10) begin
            hh = 4'd1;
            hl = 4'(h_disp - 5'd10);
        end else begin
            hh = 4'd0;
            hl = 4'(h_disp);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tim       <= '0;
            alm       <= '0;
            presc     <= '0;
            work_d    <= 1'b1;
            match_q   <= 1'b0;
            data      <= '0;
            pm        <= 1'b0;
            sec_pulse <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            work_d    <= work_en;
            presc     <= (!work_en || tick) ? '0 : presc + PW'(1);
            tim       <= tim_n;
            alm       <= alm_n;
            sec_pulse <= tick;
            // Compare against the alarm as it stood before any write this cycle.
            match_q   <= tick && alarm_en && (tim_adv == alm);
            alarm_hit <= match_q;
            data      <= {hh, hl, tim[3], tim[2], tim[1], tim[0]};
            pm        <= pm_n;
        end
    end
endmodule

// File: tb/tb_rtc_bcd_core.sv
// tb/tb_rtc_bcd_core.sv - scoreboard testbench for rtc_bcd_core
module tb_rtc_bcd_core;
    logic        clk = 1'b0;
    logic        rst_n, work_en, set_flag, set_target, mode_12h, alarm_en;
    logic [2:0]  set_pos;
    logic [3:0]  set_data;
    logic [23:0] data0, data1;
    logic [5:0]  point0, point1;
    logic        sign0, sign1, pm0, pm1, sp0, sp1, hit0, hit1;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    int hits0 = 0;
    int hits1 = 0;

    typedef struct {
        string       name;
        int          at;
        logic [23:0] d0;
        logic [23:0] d1;
        logic        pm;
        logic        sp;
        logic        hit;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_bcd_core #(.TICK_DIV(4), .CLR_ON_STOP(1'b0), .POINT_MASK(6'b010100)) u_hold (
        .clk(clk), .rst_n(rst_n), .work_en(work_en), .set_flag(set_flag),
        .set_target(set_target), .set_pos(set_pos), .set_data(set_data),
        .mode_12h(mode_12h), .alarm_en(alarm_en), .data(data0), .point(point0),
        .sign(sign0), .pm(pm0), .sec_pulse(sp0), .alarm_hit(hit0));

    rtc_bcd_core #(.TICK_DIV(4), .CLR_ON_STOP(1'b1), .POINT_MASK(6'b010100)) u_clr (
        .clk(clk), .rst_n(rst_n), .work_en(work_en), .set_flag(set_flag),
        .set_target(set_target), .set_pos(set_pos), .set_data(set_data),
        .mode_12h(mode_12h), .alarm_en(alarm_en), .data(data1), .point(point1),
        .sign(sign1), .pm(pm1), .sec_pulse(sp1), .alarm_hit(hit1));

    // Monitor: compares every scheduled expectation on the cycle it falls due.
    always @(negedge clk) begin
        logic [67:0] act, want;
        if (hit0) hits0++;
        if (hit1) hits1++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                act  = {data0, data1, pm0, pm1, sp0, sp1, hit0, hit1,
                        point0, point1, sign0, sign1};
                want = {sb[i].d0, sb[i].d1, {2{sb[i].pm}}, {2{sb[i].sp}},
                        {2{sb[i].hit}}, 6'b010100, 6'b010100, 2'b00};
                n_total++;
                if (act === want) n_pass++;
                else $display("FAIL %s: got %h expected %h (d0,d1,pm,sp,hit,point,sign)",
                              sb[i].name, act, want);
                sb.delete(i);
            end
        end
    end

    task automatic push(input string name, input int lat, input logic [23:0] d0,
                        input logic [23:0] d1, input logic pmv, input logic spv,
                        input logic hitv);
        exp_t e;
        e.name = name; e.at = cyc + lat; e.d0 = d0; e.d1 = d1;
        e.pm = pmv; e.sp = spv; e.hit = hitv;
        sb.push_back(e);
    endtask

    task automatic wr(input logic tgt, input logic [2:0] pos, input logic [3:0] val,
                      input bit chk, input logic [23:0] d0, input logic [23:0] d1,
                      input logic pmv, input string name);
        set_flag = 1'b1; set_target = tgt; set_pos = pos; set_data = val;
        if (chk) push(name, 2, d0, d1, pmv, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        set_flag = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [2:0]  p1[6]  = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [3:0]  v1[6]  = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9};
    logic [2:0]  rp[10] = '{3'd4, 3'd5, 3'd1, 3'd0, 3'd6, 3'd3, 3'd5, 3'd4, 3'd5, 3'd4};
    logic [3:0]  rv[10] = '{4'd5, 4'd2, 4'd7, 4'd10, 4'd1, 4'd6, 4'd3, 4'd3, 4'd2, 4'd4};
    logic [23:0] rx[10] = '{24'h050000, 24'h050000, 24'h050000, 24'h050000, 24'h050000,
                            24'h050000, 24'h050000, 24'h030000, 24'h230000, 24'h230000};
    logic [2:0]  mp[4]  = '{3'd5, 3'd4, 3'd5, 3'd4};
    logic [3:0]  mv[4]  = '{4'd1, 4'd2, 4'd0, 4'd0};
    logic [23:0] mx[4]  = '{24'h010000, 24'h120000, 24'h020000, 24'h120000};
    logic        mpm[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0; work_en = 1'b1; set_flag = 1'b0; set_target = 1'b0;
        set_pos = 3'd0; set_data = 4'd0; mode_12h = 1'b0; alarm_en = 1'b0;
        repeat (2) @(negedge clk);
        push("reset", 1, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Run from reset: tick on the 4th running cycle.
        rst_n = 1'b1;
        push("data_after_rst", 1, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        push("sec_pulse1", 4, 24'h0, 24'h0, 1'b0, 1'b1, 1'b0);
        push("first_sec", 5, 24'h000001, 24'h000001, 1'b0, 1'b0, 1'b0);
        push("pulse_gap", 7, 24'h000001, 24'h000001, 1'b0, 1'b0, 1'b0);
        push("sec_pulse2", 8, 24'h000001, 24'h000001, 1'b0, 1'b1, 1'b0);
        push("second_sec", 9, 24'h000002, 24'h000002, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);

        // Stop: hold vs clear variants.
        work_en = 1'b0;
        push("stop_hold", 2, 24'h000002, 24'h000000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 6; i++)
            wr(1'b0, p1[i], v1[i], i == 5, 24'h235959, 24'h235959, 1'b0, "set_235959");

        // Resume: full cascade onto midnight on one tick.
        set_flag = 1'b0; work_en = 1'b1;
        push("wrap_pulse", 4, 24'h235959, 24'h235959, 1'b0, 1'b1, 1'b0);
        push("wrap_000000", 5, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);

        // Stopped: range-checked writes.
        work_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++)
            wr(1'b0, rp[i], rv[i], 1'b1, rx[i], rx[i], 1'b0, $sformatf("set_chk%0d", i));
        idle(1);

        // 12-hour conversion.
        mode_12h = 1'b1;
        push("mode12_h23", 1, 24'h110000, 24'h110000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            wr(1'b0, mp[i], mv[i], 1'b1, mx[i], mx[i], mpm[i], $sformatf("mode12_%0d", i));
        idle(1);
        mode_12h = 1'b0;
        push("mode24_back", 1, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Alarm 00:00:02; time set equal to alarm must not fire.
        alarm_en = 1'b1;
        wr(1'b1, 3'd0, 4'd2, 1'b1, 24'h0, 24'h0, 1'b0, "alarm_set");
        wr(1'b0, 3'd0, 4'd2, 1'b1, 24'h000002, 24'h000002, 1'b0, "time_eq_alarm");
        wr(1'b0, 3'd0, 4'd0, 1'b1, 24'h0, 24'h0, 1'b0, "time_clear");
        set_flag = 1'b0; work_en = 1'b1;
        push("alarm_s1", 5, 24'h000001, 24'h000001, 1'b0, 1'b0, 1'b0);
        push("alarm_pulse2", 8, 24'h000001, 24'h000001, 1'b0, 1'b1, 1'b0);
        push("alarm_hit", 9, 24'h000002, 24'h000002, 1'b0, 1'b0, 1'b1);
        push("alarm_once", 10, 24'h000002, 24'h000002, 1'b0, 1'b0, 1'b0);
        repeat (13) @(negedge clk);

        // Stop at 00:00:03.
        work_en = 1'b0;
        push("clr_stop", 2, 24'h000003, 24'h000000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        work_en = 1'b1; mode_12h = 1'b1;
        push("mode12_running", 1, 24'h120003, 24'h120000, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset on the tick cycle wins.
        rst_n = 1'b0;
        push("reset_mid", 1, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push("post_reset_12h", 1, 24'h120000, 24'h120000, 1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            n_total++;
            $display("FAIL %s: not reached, due at cycle %0d now %0d", sb[0].name, sb[0].at, cyc);
            sb.delete(0);
        end

        n_total++;
        if (hits0 == 1) n_pass++;
        else $display("FAIL hit_count_hold: got %0d expected 1", hits0);
        n_total++;
        if (hits1 == 1) n_pass++;
        else $display("FAIL hit_count_clr: got %0d expected 1", hits1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
